farrow_out_fifo: RTL and testbench
==================================

Name: farrow_out_fifo

Overview:
- Downstream stage of the Farrow fractional-delay resampler.
- Captures each 9-bit resampled output sample on the resampler's output strobe and buffers it in a small FIFO.
- Presents samples to a consumer through a valid/ready handshake, decoupling the irregular 3-of-12-cycle resampler output cadence from a back-pressuring sink.
- Reports fill level, a sticky overflow flag and a saturating drop counter.

Parameters:
- DEPTH, 8, FIFO depth in samples; must be a power of 2, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).
- DW, 9, sample width; matches the resampler's y_out.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ena_in  input  1  resampler output-enable strobe (the resampler's ena_out_o).
- x_in  input  DW (signed)  resampler sample (the resampler's y_out); valid one clock after ena_in.
- m_ready  input  1  consumer ready.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.
- y_out  output  DW (signed)  head-of-FIFO sample.
- y_valid  output  1  y_out holds a valid sample.
- level  output  AW+1  number of stored samples, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky: at least one sample dropped.
- drop_cnt  output  8  dropped-sample count; saturates at 255.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): all of the following clear to 0 immediately:
  - pointers, level, ena_d, overflow, drop_cnt;
  - all memory words, so y_out = 0;
  - y_valid and full, which are therefore 0.
- Capture alignment: the resampler registers y_out on the same edge at which its ena_out is high.
  - The block registers ena_in into ena_d.
  - wr_stb = ena_d; x_in is written on the edge where ena_d = 1.
  - Strobe at edge k → write at edge k+1 → y_valid = 1 after edge k+1 when the FIFO was empty.
- Read:
  - rd_fire = y_valid & m_ready.
  - On rd_fire the read pointer advances (mod DEPTH) at the clock edge.
- Output path:
  - y_out = mem[rd_ptr]; first-word-fall-through.
  - There is no bypass path: a write into an empty FIFO is visible only after the write edge.
  - y_valid = (level != 0); full = (level == DEPTH).
  - y_out must hold stable while y_valid = 1 and m_ready = 0.
  - When empty, y_out shows the stale last word; consumers ignore it.
- Write acceptance: a write is accepted when wr_stb & (!full | rd_fire). Full with a simultaneous read accepts the write.
- Level update:
  - +1 on an accepted write without rd_fire;
  - −1 on rd_fire without a write;
  - unchanged when both or neither occur.
- Drop:
  - Condition: wr_stb & full & !rd_fire.
  - Sample discarded; memory and pointers unchanged.
  - overflow set to 1.
  - drop_cnt incremented, saturating at 255.
- clr_ovf:
  - Clears overflow and drop_cnt on the next edge.
  - If a drop occurs on the same edge, the drop wins: overflow = 1, drop_cnt = 1.
- Pointer wrap: pointers are AW bits and wrap naturally DEPTH−1 → 0. Level is tracked separately; the full/empty ambiguity is resolved by level, not pointer compare.
- Arithmetic: pass-through only; no rounding, scaling or sign change. Samples are stored bit-exact.
- Strobe spacing: a new wr_stb on consecutive cycles is legal and must be handled, even though the resampler never produces it.

Test Plan:
- Reset, then ena_in pulse at cycle 3 with x_in = −37 at cycle 4, m_ready = 0 → y_valid rises after cycle-4 edge; y_out = −37; level = 1.
- Drive resampler pattern (ena_in at count 3, 7, 11) with samples 10, 20, 30, 40 and m_ready = 1 → y_out sequence 10, 20, 30, 40, each consumed one cycle after write; level never exceeds 1.
- m_ready = 0 for 10 writes of 1..10, DEPTH = 8 → level = 8, full = 1, overflow = 1, drop_cnt = 2; reading yields 1..8 in order, then y_valid = 0.
- FIFO full with m_ready = 1 and wr_stb in the same cycle → write accepted, level stays 8, overflow unchanged.
- Drive 300 writes while m_ready = 0 → drop_cnt = 255 (saturated); clr_ovf pulse → drop_cnt = 0, overflow = 0; clr_ovf coincident with a drop → overflow = 1, drop_cnt = 1.
- Assert reset mid-stream with level = 5 → all outputs 0 immediately (asynchronously); next write after release appears as the first sample; no old data emerges.

Source files
------------

// File: rtl/farrow_out_fifo.sv
// ---------------------------------------------------------------------------
// farrow_out_fifo
//
// Output buffer for the Farrow fractional-delay resampler. A one-cycle
// delayed copy of the resampler's output strobe captures each sample into a
// small first-word-fall-through FIFO. The FIFO drains to a consumer over a
// valid/ready handshake. The block also reports the fill level, a sticky
// overflow flag and a saturating count of dropped samples.
//
// Handshake: a sample moves to the consumer on a rising edge where
// y_valid = 1 and m_ready = 1. y_valid never depends on m_ready. While
// y_valid = 1 and m_ready = 0, y_out holds its value. The producer side
// has no back-pressure. A strobe that arrives while the FIFO is full, and
// no read happens on the same edge, drops its sample.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   ena_in    in   resampler output strobe (sample follows one clock later)
//   x_in      in   DW-bit signed resampler sample
//   m_ready   in   consumer ready
//   clr_ovf   in   synchronous clear of overflow / drop_cnt
//   y_out     out  head-of-FIFO sample (stale last word when empty)
//   y_valid   out  y_out holds a valid sample
//   level     out  stored samples, 0..DEPTH
//   full      out  level == DEPTH
//   overflow  out  sticky: at least one sample dropped
//   drop_cnt  out  dropped-sample count, saturates at 255
// ---------------------------------------------------------------------------
module farrow_out_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena_in,
  input  logic signed [DW-1:0] x_in,
  input  logic                 m_ready,
  input  logic                 clr_ovf,
  output logic signed [DW-1:0] y_out,
  output logic                 y_valid,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  // Storage and state
  logic signed [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_level;
  logic                 r_ena_d;
  logic                 r_overflow;
  logic [7:0]           r_drop_cnt;

  // Control
  logic w_wr_stb;
  logic w_full;
  logic w_valid;
  logic w_rd_fire;
  logic w_wr_acc;
  logic w_drop;

  // The resampler registers its sample on the same edge that its strobe is
  // high. The sample is therefore stable during the cycle after the strobe,
  // and we write on the delayed strobe.
  assign w_wr_stb  = r_ena_d;
  assign w_full    = (r_level == LP_FULL);
  assign w_valid   = (r_level != '0);
  assign w_rd_fire = w_valid & m_ready;

  // When the FIFO is full, a read on the same edge frees the head slot. The
  // incoming write then goes into that slot: the write pointer equals the
  // read pointer when the FIFO is full.
  assign w_wr_acc  = w_wr_stb & (~w_full | w_rd_fire);
  assign w_drop    = w_wr_stb & w_full & ~w_rd_fire;

  // Strobe delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ena_d <= 1'b0;
    end else begin
      r_ena_d <= ena_in;
    end
  end

  // Sample memory. Reset clears every word so that y_out reads 0 right away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= x_in;
    end
  end

  // Pointers wrap naturally. Level separates full from empty, so the
  // pointers are never compared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
    end else begin
      case ({w_wr_acc, w_rd_fire})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Overflow bookkeeping. A drop on the same edge as clr_ovf takes priority:
  // the clear happens, and the drop is then counted as the first one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // Outputs. y_out is a first-word-fall-through read and has no bypass
  // from x_in.
  assign y_out    = r_mem[r_rd_ptr];
  assign y_valid  = w_valid;
  assign level    = r_level;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_farrow_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_farrow_out_fifo
//
// Directed bench for farrow_out_fifo (DEPTH=8, DW=9). Inputs change and
// outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_farrow_out_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 9;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic                 ena_in;
  logic signed [DW-1:0] x_in;
  logic                 m_ready;
  logic                 clr_ovf;
  logic signed [DW-1:0] y_out;
  logic                 y_valid;
  logic [AW:0]          level;
  logic                 full;
  logic                 overflow;
  logic [7:0]           drop_cnt;

  farrow_out_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .ena_in   (ena_in),
    .x_in     (x_in),
    .m_ready  (m_ready),
    .clr_ovf  (clr_ovf),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] z9(input logic [DW-1:0] v);
    return {23'd0, v};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The strobe is high for one cycle. The sample is presented during the
  // next cycle and is written at the end of that cycle.
  task automatic wr_sample(input logic [DW-1:0] v);
    ena_in = 1'b1;
    step();
    ena_in = 1'b0;
    x_in   = v;
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_y_out"},    z9(y_out), 32'd0);
    chk({tag, "_y_valid"},  {31'd0, y_valid}, 32'd0);
    chk({tag, "_level"},    {28'd0, level}, 32'd0);
    chk({tag, "_full"},     {31'd0, full}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  task automatic drain_and_check(input string tag, input int n);
    logic [DW-1:0] e;
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, {31'd0, y_valid}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, z9(y_out), z9(e));
      end
      step();
    end
    m_ready = 1'b0;
    chk({tag, "_empty"}, {31'd0, y_valid}, 32'd0);
  endtask

  logic [DW-1:0] v;

  initial begin
    reset   = 1'b1;
    ena_in  = 1'b0;
    x_in    = '0;
    m_ready = 1'b0;
    clr_ovf = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    step();
    reset = 1'b0;
    step();

    // Single capture: no bypass, value -37 (9'h1DB), held without ready
    ena_in = 1'b1;
    step();
    ena_in = 1'b0;
    x_in   = -9'sd37;
    chk("t1_no_bypass", {31'd0, y_valid}, 32'd0);
    step();
    chk("t1_valid", {31'd0, y_valid}, 32'd1);
    chk("t1_y_out", z9(y_out), 32'h1DB);
    chk("t1_level", {28'd0, level}, 32'd1);
    step();
    step();
    chk("t1_hold", z9(y_out), 32'h1DB);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t1_drained", {28'd0, level}, 32'd0);

    // Resampler cadence with a ready consumer
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      v = DW'(10 * i);
      wr_sample(v);
      chk("t2_valid", {31'd0, y_valid}, 32'd1);
      chk("t2_data", z9(y_out), z9(v));
      chk("t2_level1", {28'd0, level}, 32'd1);
      step();
      chk("t2_level0", {28'd0, level}, 32'd0);
      step();
    end
    m_ready = 1'b0;

    // Overfill: 10 writes into depth 8
    for (int i = 1; i <= 10; i++) begin
      v = DW'(i);
      wr_sample(v);
      if (i <= DEPTH) exp_q.push_back(v);
    end
    chk("t3_level", {28'd0, level}, 32'd8);
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    drain_and_check("t3_rd", DEPTH);
    chk("t3_level0", {28'd0, level}, 32'd0);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Full, with a read on the same edge as the write
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'(101 + i);
      wr_sample(v);
      exp_q.push_back(v);
    end
    chk("t4_full", {31'd0, full}, 32'd1);
    ena_in = 1'b1;
    step();
    ena_in  = 1'b0;
    x_in    = 9'd77;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(9'd77);
    chk("t4_level", {28'd0, level}, 32'd8);
    chk("t4_overflow", {31'd0, overflow}, 32'd0);
    chk("t4_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("t4_head", z9(y_out), 32'd102);
    drain_and_check("t4_rd", DEPTH);

    // Drop saturation: 300 consecutive strobes with no reads
    ena_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x_in = DW'(i);
      step();
    end
    ena_in = 1'b0;
    step();
    chk("t5_level", {28'd0, level}, 32'd8);
    chk("t5_drop_sat", {24'd0, drop_cnt}, 32'd255);
    chk("t5_overflow", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_clr_ovf", {31'd0, overflow}, 32'd0);
    chk("t5_clr_cnt", {24'd0, drop_cnt}, 32'd0);
    ena_in = 1'b1;
    step();
    ena_in  = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_race_ovf", {31'd0, overflow}, 32'd1);
    chk("t5_race_cnt", {24'd0, drop_cnt}, 32'd1);

    // Asynchronous reset mid-stream
    pulse_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      v = DW'(200 + i);
      wr_sample(v);
    end
    chk("t6_level5", {28'd0, level}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t6_async");
    #2;
    reset = 1'b0;
    step();
    v = 9'd55;
    wr_sample(v);
    exp_q.push_back(v);
    chk("t6_level1", {28'd0, level}, 32'd1);
    drain_and_check("t6_rd", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
